// File: rtl/fortuna_reader_pkg.sv
// Shared types and sizing helpers for the Fortuna block reader.
// Used by fortuna_block_reader and its block_serializer.
package fortuna_reader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        STREAM = 2'd3
    } rd_state_e;

    localparam int BYTE_W = 8;

    function automatic int bytes_per_block(input int block_w);
        return block_w / BYTE_W;
    endfunction

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fortuna_block_reader_serializer.sv
// block_serializer: parallel-load block, emits one byte per valid/ready handshake; tx_valid registered.
// Byte order LSB-first by default, MSB-first when FORTUNA_READER_MSB_FIRST_EN is defined.
module block_serializer
    import fortuna_reader_pkg::*;
#(
    parameter int BLOCK_W = 512
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [BLOCK_W-1:0] load_dat_i,
    output logic [BYTE_W-1:0]  tx_dat_o,
    output logic               tx_vld_o,
    input  logic               tx_rdy_i,
    output logic               tx_last_o,
    output logic               done_o
);

    localparam int NBYTES = bytes_per_block(BLOCK_W);
    localparam int CW     = ctr_width(NBYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    logic [BLOCK_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               vld_q, vld_d;
    logic               hs;
    logic               at_last;

    assign hs      = vld_q & tx_rdy_i;
    assign at_last = (cnt_q == LAST_IDX);

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        if (load_i) begin
            shreg_d = load_dat_i;
            cnt_d   = '0;
            vld_d   = 1'b1;
        end else if (hs) begin
`ifdef FORTUNA_READER_MSB_FIRST_EN
            shreg_d = shreg_q << BYTE_W;
`else
            shreg_d = shreg_q >> BYTE_W;
`endif
            cnt_d = cnt_q + CW'(1);
            if (at_last) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
        end
    end

`ifdef FORTUNA_READER_MSB_FIRST_EN
    assign tx_dat_o = shreg_q[BLOCK_W-1 -: BYTE_W];
`else
    assign tx_dat_o = shreg_q[BYTE_W-1:0];
`endif
    // Gated with valid so a one-byte block cannot leave tx_last stuck high.
    assign tx_vld_o  = vld_q;
    assign tx_last_o = vld_q & at_last;
    assign done_o    = hs & at_last;

endmodule

// File: rtl/fortuna_block_reader.sv
// Requests a block from the Fortuna accelerator, waits for a fresh valid, streams it out bytewise.
// First tx byte one cycle after capture; byte order selected by FORTUNA_READER_MSB_FIRST_EN.
module fortuna_block_reader
    import fortuna_reader_pkg::*;
#(
    parameter int BLOCK_W        = 512,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    output logic               gen_data,
    input  logic               acc_busy,
    input  logic               acc_valid,
    input  logic [BLOCK_W-1:0] acc_data,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               tx_last,
    output logic               rd_busy,
    output logic               timeout_err
);

    localparam int TW = ctr_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    rd_state_e     state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          seen_busy_q, seen_busy_d;
    logic          err_q, err_d;
    logic          load;
    logic          ser_done;

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        seen_busy_d = seen_busy_q;
        err_d       = err_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !acc_busy) begin
                    state_d = REQ;
                    err_d   = 1'b0;
                end
            end
            REQ: begin
                state_d     = WAIT;
                tmo_d       = '0;
                seen_busy_d = acc_busy;
            end
            WAIT: begin
                seen_busy_d = seen_busy_q | acc_busy;
                // A valid is only trusted once the accelerator has gone busy for this request.
                if (acc_valid && !acc_busy && seen_busy_q) begin
                    load    = 1'b1;
                    state_d = STREAM;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            STREAM: begin
                if (ser_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            seen_busy_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            seen_busy_q <= seen_busy_d;
            err_q       <= err_d;
        end
    end

    assign gen_data    = (state_q == REQ);
    assign rd_busy     = (state_q != IDLE);
    assign timeout_err = err_q;

    block_serializer #(
        .BLOCK_W (BLOCK_W)
    ) u_ser (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (load),
        .load_dat_i (acc_data),
        .tx_dat_o   (tx_data),
        .tx_vld_o   (tx_valid),
        .tx_rdy_i   (tx_ready),
        .tx_last_o  (tx_last),
        .done_o     (ser_done)
    );

endmodule

// File: tb/tb_fortuna_block_reader.sv
// Directed bench for fortuna_block_reader with a scripted accelerator model and byte collector.
module tb_fortuna_block_reader;

    localparam int BW  = 512;
    localparam int NB  = BW / 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          gen_data;
    logic          acc_busy;
    logic          acc_valid;
    logic [BW-1:0] acc_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_last;
    logic          rd_busy;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] blk_inc;
    logic [BW-1:0] blk_new;
    logic [BW-1:0] blk_stale;

    always #5 clk = ~clk;

    fortuna_block_reader #(
        .BLOCK_W        (BW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gen_data    (gen_data),
        .acc_busy    (acc_busy),
        .acc_valid   (acc_valid),
        .acc_data    (acc_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_last     (tx_last),
        .rd_busy     (rd_busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [BW-1:0] blk, input int k);
`ifdef FORTUNA_READER_MSB_FIRST_EN
        return blk[(NB-1-k)*8 +: 8];
`else
        return blk[k*8 +: 8];
`endif
    endfunction

    function automatic logic [BW-1:0] mk_block(input logic [7:0] base);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < NB; i++) b[i*8 +: 8] = base + 8'(i);
        return b;
    endfunction

    // Raises req for one accepted cycle; returns at the negedge of the REQ cycle.
    task automatic issue_req();
        @(posedge clk); #1;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("gen_data_after_req", gen_data, 1);
        check("rd_busy_req", rd_busy, 1);
    endtask

    // Accelerator: idle for dly cycles after gen_data, busy for blen cycles, then valid with blk.
    task automatic accel(input int dly, input int blen, input logic [BW-1:0] blk);
        logic early = 1'b0;
        logic regen = 1'b0;
        repeat (dly) begin
            @(negedge clk);
            early |= tx_valid;
            regen |= gen_data;
        end
        check("early_capture", early, 0);
        check("gen_data_single", regen, 0);
        @(posedge clk); #1;
        acc_busy = 1'b1;
        repeat (blen) begin
            @(posedge clk); #1;
        end
        acc_busy  = 1'b0;
        acc_valid = 1'b1;
        acc_data  = blk;
    endtask

    // Collects stop_at bytes; bp selects the 1,0,0,1 tx_ready pattern.
    task automatic collect(input bit bp, input int stop_at, input logic [BW-1:0] blk);
        int         k        = 0;
        int         cyc      = 0;
        int         unstable = 0;
        bit         stalled  = 1'b0;
        logic [7:0] held     = 8'h00;
        logic [1:0] ph;
        while (k < stop_at && cyc < 600) begin
            ph       = 2'(cyc % 4);
            tx_ready = !bp || (ph == 2'd0) || (ph == 2'd3);
            @(negedge clk);
            if (stalled && tx_valid && (tx_data !== held)) unstable++;
            if (tx_valid && tx_ready) begin
                check("byte", {24'h0, tx_data}, {24'h0, exp_byte(blk, k)});
                check("tx_last", tx_last, (k == NB - 1) ? 1 : 0);
                k++;
            end
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
            @(posedge clk); #1;
            cyc++;
        end
        tx_ready = 1'b1;
        check("handshakes", k, stop_at);
        if (bp) check("stall_stable", unstable, 0);
    endtask

    task automatic check_block_end();
        @(negedge clk);
        check("end_tx_valid", tx_valid, 0);
        check("end_rd_busy", rd_busy, 0);
    endtask

    initial begin
        int  n;
        bit  done;
        logic seen;

        blk_inc   = mk_block(8'h00);
        blk_new   = mk_block(8'hA5);
        blk_stale = {64{8'h11}};

        rst       = 1'b1;
        req       = 1'b0;
        acc_busy  = 1'b0;
        acc_valid = 1'b0;
        acc_data  = '0;
        tx_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_gen_data", gen_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_last", tx_last, 0);
        check("rst_rd_busy", rd_busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_tx_data", {24'h0, tx_data}, 0);

        // Request while accelerator busy must be dropped.
        @(posedge clk); #1;
        acc_busy = 1'b1;
        req      = 1'b1;
        seen     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= rd_busy | gen_data;
        end
        check("req_blocked_by_busy", seen, 0);
        @(posedge clk); #1;
        req      = 1'b0;
        acc_busy = 1'b0;

        // Basic read.
        issue_req();
        accel(1, 10, blk_inc);
        collect(1'b0, NB, blk_inc);
        check_block_end();

        // Backpressure read; stale valid from the previous block is still high.
        issue_req();
        accel(1, 10, blk_inc);
        collect(1'b1, NB, blk_inc);
        check_block_end();

        // Stale valid with different data must not be captured before busy.
        @(posedge clk); #1;
        acc_valid = 1'b1;
        acc_data  = blk_stale;
        issue_req();
        accel(5, 3, blk_new);
        collect(1'b0, NB, blk_new);
        check_block_end();

        // Timeout: accelerator never responds.
        @(posedge clk); #1;
        acc_valid = 1'b0;
        acc_busy  = 1'b0;
        issue_req();
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            if (!rd_busy) done = 1'b1;
            else n++;
        end
        check("timeout_wait_cycles", n, TMO);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_no_tx", tx_valid, 0);
        repeat (3) @(negedge clk);
        check("timeout_err_sticky", timeout_err, 1);

        // Next accepted req clears the error; then reset in the middle of the stream.
        issue_req();
        check("timeout_err_cleared", timeout_err, 0);
        accel(1, 10, blk_inc);
        collect(1'b0, 20, blk_inc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_rd_busy", rd_busy, 0);
        check("midrst_timeout_err", timeout_err, 0);
        check("midrst_tx_data", {24'h0, tx_data}, 0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= tx_valid;
        end
        check("midrst_quiet", seen, 0);

        // Full block after the reset.
        acc_valid = 1'b0;
        issue_req();
        accel(1, 10, blk_new);
        collect(1'b0, NB, blk_new);
        check_block_end();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (errors=%0d checks=%0d)", errors, checks);
        $fatal(1);
    end

endmodule
